// File: rtl/rvm_mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rvm_mem_ctrl_pkg
// Brief    : Size/state encodings and alignment helper for the load/store adapter.
// Revision : 1.0 - initial release
// ============================================================================
package rvm_mem_ctrl_pkg;

    localparam logic [1:0] RVM_MEM_SIZE_BYTE = 2'b00;
    localparam logic [1:0] RVM_MEM_SIZE_HALF = 2'b01;
    localparam logic [1:0] RVM_MEM_SIZE_WORD = 2'b10;
    localparam logic [1:0] RVM_MEM_SIZE_RSVD = 2'b11;

    typedef enum logic [1:0] {
        RVM_MEM_IDLE = 2'd0,
        RVM_MEM_REQ  = 2'd1,
        RVM_MEM_RSP  = 2'd2,
        RVM_MEM_DONE = 2'd3
    } rvm_mem_state_e;

    // A request is illegal when its size is reserved or its address is not naturally aligned.
    function automatic logic rvm_mem_illegal(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b1;
        case (size)
            RVM_MEM_SIZE_BYTE: bad = 1'b0;
            RVM_MEM_SIZE_HALF: bad = addr_lo[0];
            RVM_MEM_SIZE_WORD: bad = |addr_lo;
            default:           bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rvm_mem_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : rvm_mem_ctrl_if
// Brief    : Control-side request/ack bundle plus external memory bus signals.
// Revision : 1.0 - initial release
// ============================================================================
interface rvm_mem_ctrl_if #(
    parameter int ADDR_W = 32
) ();
    logic              ctrl_req;
    logic              ctrl_wen;
    logic [1:0]        ctrl_size;
    logic              ctrl_sign;
    logic [ADDR_W-1:0] ctrl_addr;
    logic [31:0]       ctrl_wdata;
    logic              ctrl_ack;
    logic              ctrl_err;
    logic [31:0]       ctrl_rdata;

    logic              mem_cen;
    logic              mem_wen;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_wstrb;
    logic [31:0]       mem_wdata;
    logic              mem_stall;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;
    logic              mem_error;

    // The adapter is the slave of the control FSM and drives the memory bus.
    modport slave (
        input  ctrl_req, ctrl_wen, ctrl_size, ctrl_sign, ctrl_addr, ctrl_wdata,
        output ctrl_ack, ctrl_err, ctrl_rdata,
        output mem_cen, mem_wen, mem_addr, mem_wstrb, mem_wdata,
        input  mem_stall, mem_rvalid, mem_rdata, mem_error
    );

    modport master (
        output ctrl_req, ctrl_wen, ctrl_size, ctrl_sign, ctrl_addr, ctrl_wdata,
        input  ctrl_ack, ctrl_err, ctrl_rdata,
        input  mem_cen, mem_wen, mem_addr, mem_wstrb, mem_wdata,
        output mem_stall, mem_rvalid, mem_rdata, mem_error
    );
endinterface
`default_nettype wire

// File: rtl/rvm_mem_lane.sv
`default_nettype none
// ============================================================================
// Module   : rvm_mem_lane
// Brief    : Combinational byte-lane steering: strobes, write replication, read extract/extend.
// Revision : 1.0 - initial release
// ============================================================================
module rvm_mem_lane
    import rvm_mem_ctrl_pkg::*;
(
    input  wire logic [1:0]  i_size,
    input  wire logic [1:0]  i_addr_lo,
    input  wire logic        i_sign,
    input  wire logic [31:0] i_wdata,
    input  wire logic [31:0] i_rdata,
    output logic      [3:0]  o_wstrb,
    output logic      [31:0] o_wdata,
    output logic      [31:0] o_rdata
);

    logic [31:0] w_shifted;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_shifted = i_rdata >> {i_addr_lo, 3'b000};
        w_byte    = w_shifted[7:0];
        w_half    = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
        o_wstrb   = 4'b1111;
        o_wdata   = i_wdata;
        o_rdata   = i_rdata;
        case (i_size)
            RVM_MEM_SIZE_BYTE: begin
                o_wstrb = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_wdata[7:0]}};
                o_rdata = {{24{i_sign & w_byte[7]}}, w_byte};
            end
            RVM_MEM_SIZE_HALF: begin
                o_wstrb = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata = {2{i_wdata[15:0]}};
                o_rdata = {{16{i_sign & w_half[15]}}, w_half};
            end
            default: begin
                o_wstrb = 4'b1111;
                o_wdata = i_wdata;
                o_rdata = i_rdata;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/rvm_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rvm_mem_ctrl
// Brief    : One-at-a-time load/store adapter between the control FSM and the memory bus.
//            Optional bus watchdog enabled by defining RVM_MEM_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module rvm_mem_ctrl
    import rvm_mem_ctrl_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  wire logic       clk,
    input  wire logic       resetn,
    rvm_mem_ctrl_if.slave   bus
);

    rvm_mem_state_e    state_q, state_d;
    logic              wen_q, wen_d;
    logic [1:0]        size_q, size_d;
    logic              sign_q, sign_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              err_q, err_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              w_timeout;

    logic [3:0]        w_wstrb;
    logic [31:0]       w_wdata_rep;
    logic [31:0]       w_rdata_ext;

    rvm_mem_lane u_lane (
        .i_size    (size_q),
        .i_addr_lo (addr_q[1:0]),
        .i_sign    (sign_q),
        .i_wdata   (wdata_q),
        .i_rdata   (bus.mem_rdata),
        .o_wstrb   (w_wstrb),
        .o_wdata   (w_wdata_rep),
        .o_rdata   (w_rdata_ext)
    );

`ifdef RVM_MEM_TIMEOUT_EN
    localparam logic [7:0] C_TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == RVM_MEM_IDLE) begin
            cnt_d = 8'd0;
        end else if (state_q == RVM_MEM_REQ || state_q == RVM_MEM_RSP) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign w_timeout = (cnt_q == C_TIMEOUT_LAST);
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        wen_d   = wen_q;
        size_d  = size_q;
        sign_d  = sign_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        case (state_q)
            RVM_MEM_IDLE: begin
                if (bus.ctrl_req) begin
                    if (rvm_mem_illegal(bus.ctrl_size, bus.ctrl_addr[1:0])) begin
                        state_d = RVM_MEM_DONE;
                        err_d   = 1'b1;
                        rdata_d = 32'd0;
                    end else begin
                        state_d = RVM_MEM_REQ;
                        wen_d   = bus.ctrl_wen;
                        size_d  = bus.ctrl_size;
                        sign_d  = bus.ctrl_sign;
                        addr_d  = bus.ctrl_addr;
                        wdata_d = bus.ctrl_wdata;
                    end
                end
            end
            RVM_MEM_REQ: begin
                if (!bus.mem_stall) begin
                    state_d = RVM_MEM_RSP;
                end else if (w_timeout) begin
                    state_d = RVM_MEM_DONE;
                    err_d   = 1'b1;
                    rdata_d = 32'd0;
                end
            end
            RVM_MEM_RSP: begin
                // A response arriving on the watchdog's last cycle still wins.
                if (bus.mem_rvalid) begin
                    state_d = RVM_MEM_DONE;
                    err_d   = bus.mem_error;
                    rdata_d = (bus.mem_error || wen_q) ? 32'd0 : w_rdata_ext;
                end else if (w_timeout) begin
                    state_d = RVM_MEM_DONE;
                    err_d   = 1'b1;
                    rdata_d = 32'd0;
                end
            end
            default: begin
                state_d = RVM_MEM_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= RVM_MEM_IDLE;
            wen_q   <= 1'b0;
            size_q  <= 2'b00;
            sign_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            wen_q   <= wen_d;
            size_q  <= size_d;
            sign_q  <= sign_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    logic w_in_req;
    logic w_in_done;

    assign w_in_req       = (state_q == RVM_MEM_REQ);
    assign w_in_done      = (state_q == RVM_MEM_DONE);

    assign bus.ctrl_ack   = w_in_done;
    assign bus.ctrl_err   = w_in_done & err_q;
    assign bus.ctrl_rdata = w_in_done ? rdata_q : 32'd0;

    assign bus.mem_cen    = w_in_req;
    assign bus.mem_wen    = w_in_req & wen_q;
    assign bus.mem_addr   = w_in_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign bus.mem_wstrb  = (w_in_req && wen_q) ? w_wstrb : 4'b0000;
    assign bus.mem_wdata  = w_in_req ? w_wdata_rep : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_rvm_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_rvm_mem_ctrl
// Brief    : Directed vector bench for rvm_mem_ctrl (timeout case needs RVM_MEM_TIMEOUT_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rvm_mem_ctrl;
    import rvm_mem_ctrl_pkg::*;

    localparam int ADDR_W = 32;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    rvm_mem_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    rvm_mem_ctrl #(
        .ADDR_W         (ADDR_W),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        wen;
        logic [1:0]  size;
        logic        sign;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        merr;
        logic        legal;
        logic        err;
        logic [31:0] rres;
        logic [3:0]  wstrb;
        logic [31:0] mwdata;
        logic [31:0] maddr;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, " ack"},   32'(bus.ctrl_ack),   32'd0);
        chk({tag, " err"},   32'(bus.ctrl_err),   32'd0);
        chk({tag, " rdata"}, bus.ctrl_rdata,      32'd0);
        chk({tag, " cen"},   32'(bus.mem_cen),    32'd0);
        chk({tag, " wen"},   32'(bus.mem_wen),    32'd0);
        chk({tag, " maddr"}, bus.mem_addr,        32'd0);
        chk({tag, " wstrb"}, 32'(bus.mem_wstrb),  32'd0);
        chk({tag, " mwdat"}, bus.mem_wdata,       32'd0);
    endtask

    task automatic chk_bus(input string tag, input logic wen, input logic [31:0] maddr,
                           input logic [3:0] wstrb, input logic [31:0] mwdata);
        chk({tag, " cen"},   32'(bus.mem_cen),   32'd1);
        chk({tag, " wen"},   32'(bus.mem_wen),   32'(wen));
        chk({tag, " maddr"}, bus.mem_addr,       maddr);
        chk({tag, " wstrb"}, 32'(bus.mem_wstrb), 32'(wstrb));
        chk({tag, " mwdat"}, bus.mem_wdata,      mwdata);
        chk({tag, " ack"},   32'(bus.ctrl_ack),  32'd0);
    endtask

    task automatic apply_vec(input string tag, input vec_t v);
        bus.ctrl_req   = 1'b1;
        bus.ctrl_wen   = v.wen;
        bus.ctrl_size  = v.size;
        bus.ctrl_sign  = v.sign;
        bus.ctrl_addr  = v.addr;
        bus.ctrl_wdata = v.wdata;
        tick();
        if (v.legal) begin
            chk_bus({tag, " req"}, v.wen, v.maddr, v.wstrb, v.mwdata);
            tick();
            chk({tag, " rsp cen"}, 32'(bus.mem_cen),  32'd0);
            chk({tag, " rsp ack"}, 32'(bus.ctrl_ack), 32'd0);
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = v.rdata;
            bus.mem_error  = v.merr;
            tick();
            bus.mem_rvalid = 1'b0;
            bus.mem_rdata  = 32'd0;
            bus.mem_error  = 1'b0;
        end else begin
            chk({tag, " cen"}, 32'(bus.mem_cen), 32'd0);
        end
        chk({tag, " ack"},   32'(bus.ctrl_ack), 32'd1);
        chk({tag, " err"},   32'(bus.ctrl_err), 32'(v.err));
        chk({tag, " rdata"}, bus.ctrl_rdata,    v.rres);
        bus.ctrl_req = 1'b0;
        tick();
        chk({tag, " post ack"}, 32'(bus.ctrl_ack), 32'd0);
        chk({tag, " post cen"}, 32'(bus.mem_cen),  32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        vec_t v;
        bus.ctrl_req   = 1'b0;
        bus.ctrl_wen   = 1'b0;
        bus.ctrl_size  = 2'b00;
        bus.ctrl_sign  = 1'b0;
        bus.ctrl_addr  = 32'd0;
        bus.ctrl_wdata = 32'd0;
        bus.mem_stall  = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'd0;
        bus.mem_error  = 1'b0;

        //          wen   size   sign  addr      wdata         rdata         merr  legal err   rres          wstrb  mwdata        maddr
        vecs[0]  = '{1'b0, 2'b00, 1'b1, 32'h103, 32'h0,        32'h80FF0000, 1'b0, 1'b1, 1'b0, 32'hFFFFFF80, 4'h0, 32'h0,        32'h100};
        vecs[1]  = '{1'b1, 2'b01, 1'b0, 32'h202, 32'h0000BEEF, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 32'h0,        4'hC, 32'hBEEFBEEF, 32'h200};
        vecs[2]  = '{1'b0, 2'b10, 1'b0, 32'h101, 32'h0,        32'h0,        1'b0, 1'b0, 1'b1, 32'h0,        4'h0, 32'h0,        32'h0};
        vecs[3]  = '{1'b0, 2'b11, 1'b0, 32'h100, 32'h0,        32'h0,        1'b0, 1'b0, 1'b1, 32'h0,        4'h0, 32'h0,        32'h0};
        vecs[4]  = '{1'b0, 2'b01, 1'b0, 32'h002, 32'h0,        32'h12345678, 1'b1, 1'b1, 1'b1, 32'h0,        4'h0, 32'h0,        32'h000};
        vecs[5]  = '{1'b0, 2'b00, 1'b0, 32'h103, 32'h0,        32'h80FF0000, 1'b0, 1'b1, 1'b0, 32'h00000080, 4'h0, 32'h0,        32'h100};
        vecs[6]  = '{1'b0, 2'b01, 1'b1, 32'h006, 32'h0,        32'h80017FFF, 1'b0, 1'b1, 1'b0, 32'hFFFF8001, 4'h0, 32'h0,        32'h004};
        vecs[7]  = '{1'b0, 2'b01, 1'b1, 32'h004, 32'h0,        32'h80017FFF, 1'b0, 1'b1, 1'b0, 32'h00007FFF, 4'h0, 32'h0,        32'h004};
        vecs[8]  = '{1'b0, 2'b10, 1'b1, 32'h008, 32'h0,        32'h80000001, 1'b0, 1'b1, 1'b0, 32'h80000001, 4'h0, 32'h0,        32'h008};
        vecs[9]  = '{1'b1, 2'b00, 1'b0, 32'h301, 32'h123456A5, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        4'h2, 32'hA5A5A5A5, 32'h300};
        vecs[10] = '{1'b1, 2'b10, 1'b0, 32'h40C, 32'hCAFEF00D, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        4'hF, 32'hCAFEF00D, 32'h40C};
        vecs[11] = '{1'b1, 2'b01, 1'b0, 32'h001, 32'h0000AAAA, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0,        4'h0, 32'h0,        32'h0};
        vecs[12] = '{1'b1, 2'b00, 1'b0, 32'h002, 32'h00000011, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        4'h4, 32'h11111111, 32'h000};
        vecs[13] = '{1'b0, 2'b00, 1'b1, 32'h101, 32'h0,        32'h00007F00, 1'b0, 1'b1, 1'b0, 32'h0000007F, 4'h0, 32'h0,        32'h100};
        vecs[14] = '{1'b1, 2'b10, 1'b0, 32'h002, 32'h0,        32'h0,        1'b0, 1'b0, 1'b1, 32'h0,        4'h0, 32'h0,        32'h0};
        vecs[15] = '{1'b1, 2'b10, 1'b0, 32'h010, 32'h00000001, 32'h0,        1'b1, 1'b1, 1'b1, 32'h0,        4'hF, 32'h00000001, 32'h010};

        // Reset state
        repeat (3) tick();
        chk_idle_outputs("reset");
        resetn = 1'b1;
        tick();
        chk_idle_outputs("idle");

        for (int i = 0; i < 16; i++) begin
            apply_vec($sformatf("v%0d", i), vecs[i]);
        end

        // Store half under a three-cycle stall, then a held req restarting after DONE
        bus.ctrl_req   = 1'b1;
        bus.ctrl_wen   = 1'b1;
        bus.ctrl_size  = RVM_MEM_SIZE_HALF;
        bus.ctrl_sign  = 1'b0;
        bus.ctrl_addr  = 32'h202;
        bus.ctrl_wdata = 32'h0000BEEF;
        bus.mem_stall  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_bus($sformatf("stall%0d", k), 1'b1, 32'h200, 4'hC, 32'hBEEFBEEF);
        end
        bus.mem_stall = 1'b0;
        tick();
        chk("stall rsp cen", 32'(bus.mem_cen),  32'd0);
        chk("stall rsp ack", 32'(bus.ctrl_ack), 32'd0);
        bus.mem_rvalid = 1'b1;
        tick();
        bus.mem_rvalid = 1'b0;
        chk("stall ack",   32'(bus.ctrl_ack), 32'd1);
        chk("stall err",   32'(bus.ctrl_err), 32'd0);
        tick();
        chk("held idle cen", 32'(bus.mem_cen),  32'd0);
        chk("held idle ack", 32'(bus.ctrl_ack), 32'd0);
        tick();
        chk_bus("held req", 1'b1, 32'h200, 4'hC, 32'hBEEFBEEF);
        tick();
        bus.mem_rvalid = 1'b1;
        tick();
        bus.mem_rvalid = 1'b0;
        chk("held ack", 32'(bus.ctrl_ack), 32'd1);
        bus.ctrl_req = 1'b0;
        tick();
        chk("held post ack", 32'(bus.ctrl_ack), 32'd0);

        // Reset while waiting in RSP; late responses must not produce an ack
        bus.ctrl_req  = 1'b1;
        bus.ctrl_wen  = 1'b0;
        bus.ctrl_size = RVM_MEM_SIZE_WORD;
        bus.ctrl_addr = 32'h0;
        tick();
        tick();
        chk("pre-rst rsp cen", 32'(bus.mem_cen), 32'd0);
        bus.ctrl_req = 1'b0;
        resetn = 1'b0;
        #1;
        chk_idle_outputs("midrst");
        tick();
        resetn = 1'b1;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hFFFFFFFF;
        for (int k = 0; k < 2; k++) begin
            tick();
            chk($sformatf("late rvalid%0d ack", k), 32'(bus.ctrl_ack), 32'd0);
        end
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'd0;
        tick();
        chk_idle_outputs("post-rst");
        v = '{1'b0, 2'b10, 1'b0, 32'h000, 32'h0, 32'h55AA55AA, 1'b0, 1'b1, 1'b0, 32'h55AA55AA, 4'h0, 32'h0, 32'h000};
        apply_vec("after-rst", v);

`ifdef RVM_MEM_TIMEOUT_EN
        // Four-cycle watchdog with no response at all
        bus.ctrl_req  = 1'b1;
        bus.ctrl_wen  = 1'b0;
        bus.ctrl_size = RVM_MEM_SIZE_WORD;
        bus.ctrl_addr = 32'h010;
        tick();
        chk("to req cen", 32'(bus.mem_cen), 32'd1);
        for (int k = 2; k <= 4; k++) begin
            tick();
            chk($sformatf("to cyc%0d ack", k), 32'(bus.ctrl_ack), 32'd0);
        end
        tick();
        chk("to ack",   32'(bus.ctrl_ack),  32'd1);
        chk("to err",   32'(bus.ctrl_err),  32'd1);
        chk("to rdata", bus.ctrl_rdata,     32'd0);
        chk("to cen",   32'(bus.mem_cen),   32'd0);
        bus.ctrl_req   = 1'b0;
        bus.mem_rvalid = 1'b1;
        tick();
        bus.mem_rvalid = 1'b0;
        chk("to late ack", 32'(bus.ctrl_ack), 32'd0);
        tick();
        chk("to idle ack", 32'(bus.ctrl_ack), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
